// File: rtl/wb_stage_pkg.sv
// Shared widths, stall encoding and bus layouts
// for the write-back stage.
package wb_stage_pkg;

  localparam int MEM_TO_WB_WD = 136;
  localparam int WB_TO_RF_WD  = 104;
  localparam int STALL_WD     = 6;

  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  typedef logic [STALL_WD-1:0] stall_bus_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;
  } mem_wb_t;

  typedef struct packed {
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;
  } wb_rf_t;

endpackage

// File: rtl/wb_stage_regfile.sv
// 32x32 general register file, 2 read / 1 write,
// write-through reads, register 0 hardwired to zero.
module wb_stage_regfile
  import wb_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);

  logic [31:0] regs [32];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (we && waddr != 5'd0) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = regs[raddr1];
    if (raddr1 == 5'd0) begin
      rdata1 = '0;
    end else if (we && raddr1 == waddr) begin
      rdata1 = wdata;
    end
  end

  always_comb begin
    rdata2 = regs[raddr2];
    if (raddr2 == 5'd0) begin
      rdata2 = '0;
    end else if (we && raddr2 == waddr) begin
      rdata2 = wdata;
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: pipeline register, register file,
// HI/LO pair, forwarding bus and trace outputs.
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_WD-1:0]     stall,
  input  logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  input  logic [4:0]              raddr1,
  input  logic [4:0]              raddr2,
  output logic [31:0]             rdata1,
  output logic [31:0]             rdata2,
  output logic [31:0]             hi_rdata,
  output logic [31:0]             lo_rdata,
  output logic [WB_TO_RF_WD-1:0]  wb_to_rf_bus,
  output logic [31:0]             debug_wb_pc,
  output logic [3:0]              debug_wb_rf_wen,
  output logic [4:0]              debug_wb_rf_wnum,
  output logic [31:0]             debug_wb_rf_wdata
);

  mem_wb_t     wb_r;
  mem_wb_t     bus_in;
  wb_rf_t      fwd;
  logic        commit;
  logic        we_eff;
  logic        hi_eff;
  logic        lo_eff;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        stall_unused;

  assign bus_in       = mem_wb_t'(mem_to_wb_bus);
  assign stall_unused = ^stall[STALL_MEM-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_r <= '0;
    end else if (stall[STALL_MEM] == STOP
                 && stall[STALL_WB] == NO_STOP) begin
      wb_r <= '0;
    end else if (stall[STALL_MEM] == NO_STOP) begin
      wb_r <= bus_in;
    end
  end

  // A held instruction commits only once WB is released.
  assign commit = (stall[STALL_WB] == NO_STOP);
  assign we_eff = commit & wb_r.rf_we
                & (wb_r.rf_waddr != 5'd0);
  assign hi_eff = commit & wb_r.hi_we;
  assign lo_eff = commit & wb_r.lo_we;

  wb_stage_regfile u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (we_eff),
    .waddr  (wb_r.rf_waddr),
    .wdata  (wb_r.rf_wdata),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (hi_eff) hi_q <= wb_r.hi_wdata;
      if (lo_eff) lo_q <= wb_r.lo_wdata;
    end
  end

  assign hi_rdata = hi_eff ? wb_r.hi_wdata : hi_q;
  assign lo_rdata = lo_eff ? wb_r.lo_wdata : lo_q;

  always_comb begin
    fwd          = '0;
    fwd.rf_we    = we_eff;
    fwd.rf_waddr = wb_r.rf_waddr;
    fwd.rf_wdata = wb_r.rf_wdata;
    fwd.hi_we    = hi_eff;
    fwd.lo_we    = lo_eff;
    fwd.hi_wdata = wb_r.hi_wdata;
    fwd.lo_wdata = wb_r.lo_wdata;
  end

  assign wb_to_rf_bus      = fwd;
  assign debug_wb_pc       = wb_r.pc;
  assign debug_wb_rf_wen   = {4{we_eff}};
  assign debug_wb_rf_wnum  = wb_r.rf_waddr;
  assign debug_wb_rf_wdata = wb_r.rf_wdata;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: driver queues
// expected values, a negedge monitor compares them.
module tb_wb_stage;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [5:0]   stall = '0;
  logic [135:0] mem_to_wb_bus = '0;
  logic [4:0]   raddr1 = '0;
  logic [4:0]   raddr2 = '0;
  logic [31:0]  rdata1;
  logic [31:0]  rdata2;
  logic [31:0]  hi_rdata;
  logic [31:0]  lo_rdata;
  logic [103:0] wb_to_rf_bus;
  logic [31:0]  debug_wb_pc;
  logic [3:0]   debug_wb_rf_wen;
  logic [4:0]   debug_wb_rf_wnum;
  logic [31:0]  debug_wb_rf_wdata;

  wb_stage dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .mem_to_wb_bus     (mem_to_wb_bus),
    .raddr1            (raddr1),
    .raddr2            (raddr2),
    .rdata1            (rdata1),
    .rdata2            (rdata2),
    .hi_rdata          (hi_rdata),
    .lo_rdata          (lo_rdata),
    .wb_to_rf_bus      (wb_to_rf_bus),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  typedef enum int {
    S_RD1, S_RD2, S_HI, S_LO, S_WEN, S_WNUM,
    S_WDATA, S_PC, S_FRF, S_FHI, S_FLO
  } sel_t;

  typedef struct {
    int          cyc;
    string       name;
    sel_t        sel;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [31:0] get(sel_t s);
    case (s)
      S_RD1:   return rdata1;
      S_RD2:   return rdata2;
      S_HI:    return hi_rdata;
      S_LO:    return lo_rdata;
      S_WEN:   return {28'd0, debug_wb_rf_wen};
      S_WNUM:  return {27'd0, debug_wb_rf_wnum};
      S_WDATA: return debug_wb_rf_wdata;
      S_PC:    return debug_wb_pc;
      S_FRF:   return {31'd0, wb_to_rf_bus[103]};
      S_FHI:   return {31'd0, wb_to_rf_bus[65]};
      default: return {31'd0, wb_to_rf_bus[64]};
    endcase
  endfunction

  function automatic logic [135:0] mk(
    input logic [31:0] pc, input logic we,
    input logic [4:0] wa, input logic [31:0] wd,
    input logic hwe, input logic lwe,
    input logic [31:0] hd, input logic [31:0] ld);
    return {pc, we, wa, wd, hwe, lwe, hd, ld};
  endfunction

  task automatic ex(input string n, input sel_t s,
                    input logic [31:0] v);
    exp_t e;
    e.cyc  = cyc;
    e.name = n;
    e.sel  = s;
    e.exp  = v;
    q.push_back(e);
  endtask

  task automatic step(input logic [135:0] b,
                      input logic [5:0] st,
                      input logic [4:0] a1,
                      input logic [4:0] a2);
    @(posedge clk);
    #1;
    mem_to_wb_bus = b;
    stall  = st;
    raddr1 = a1;
    raddr2 = a2;
  endtask

  always @(negedge clk) begin
    while (q.size() != 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [31:0] act;
      e = q.pop_front();
      act = get(e.sel);
      checks++;
      if (e.cyc != cyc || act !== e.exp) begin
        failures++;
        $display("FAIL %s cyc=%0d actual=%h required=%h",
                 e.name, cyc, act, e.exp);
      end
    end
  end

  localparam logic [5:0] HOLD = 6'b111111;
  localparam logic [5:0] BUBL = 6'b011111;
  localparam logic [5:0] RUN  = 6'b000000;

  initial begin
    // in reset
    step('0, RUN, 5'd5, 5'd0);
    ex("rst_rd1", S_RD1, 32'd0);
    ex("rst_pc", S_PC, 32'd0);
    ex("rst_wen", S_WEN, 32'd0);
    ex("rst_hi", S_HI, 32'd0);
    ex("rst_lo", S_LO, 32'd0);
    rst = 1'b1;
    // A: write r8
    step(mk(32'hBFC00010, 1, 5'd8, 32'h12345678,
            0, 0, 0, 0), RUN, 5'd8, 5'd0);
    step('0, RUN, 5'd8, 5'd0);
    ex("byp_rd1", S_RD1, 32'h12345678);
    ex("a_wen", S_WEN, 32'hF);
    ex("a_wnum", S_WNUM, 32'd8);
    ex("a_wdata", S_WDATA, 32'h12345678);
    ex("a_pc", S_PC, 32'hBFC00010);
    ex("a_frf", S_FRF, 32'd1);
    // B: write to r0
    step(mk(32'hBFC00014, 1, 5'd0, 32'hFFFFFFFF,
            0, 0, 0, 0), RUN, 5'd8, 5'd0);
    ex("stored_rd1", S_RD1, 32'h12345678);
    ex("bub_wen", S_WEN, 32'd0);
    ex("bub_pc", S_PC, 32'd0);
    // C: HI and LO together
    step(mk(32'hBFC00018, 0, 5'd0, 32'd0,
            1, 1, 32'hAAAA0001, 32'h55550002),
         RUN, 5'd0, 5'd8);
    ex("r0_wen", S_WEN, 32'd0);
    ex("r0_rd1", S_RD1, 32'd0);
    ex("r0_frf", S_FRF, 32'd0);
    ex("r0_pc", S_PC, 32'hBFC00014);
    ex("r8_rd2", S_RD2, 32'h12345678);
    // D: LO only
    step(mk(32'hBFC0001C, 0, 5'd0, 32'd0,
            0, 1, 32'd0, 32'd7), RUN, 5'd0, 5'd0);
    ex("hilo_hi_byp", S_HI, 32'hAAAA0001);
    ex("hilo_lo_byp", S_LO, 32'h55550002);
    ex("hilo_fhi", S_FHI, 32'd1);
    ex("hilo_flo", S_FLO, 32'd1);
    // E: write r9, will be held
    step(mk(32'hBFC00020, 1, 5'd9, 32'hCAFEF00D,
            0, 0, 0, 0), RUN, 5'd0, 5'd0);
    ex("lo_hi_kept", S_HI, 32'hAAAA0001);
    ex("lo_only", S_LO, 32'd7);
    ex("lo_fhi", S_FHI, 32'd0);
    ex("lo_flo", S_FLO, 32'd1);
    // E in WB under full stall
    step(mk(32'hBFC00024, 1, 5'd10, 32'h11112222,
            0, 0, 0, 0), HOLD, 5'd9, 5'd0);
    ex("hold1_wen", S_WEN, 32'd0);
    ex("hold1_rd1", S_RD1, 32'd0);
    ex("hold1_pc", S_PC, 32'hBFC00020);
    ex("hold1_frf", S_FRF, 32'd0);
    ex("hold1_wnum", S_WNUM, 32'd9);
    ex("hold_lo", S_LO, 32'd7);
    step(mk(32'hBFC00024, 1, 5'd10, 32'h11112222,
            0, 0, 0, 0), HOLD, 5'd9, 5'd0);
    ex("hold2_wen", S_WEN, 32'd0);
    ex("hold2_rd1", S_RD1, 32'd0);
    ex("hold2_pc", S_PC, 32'hBFC00020);
    // release: E commits once; H queued in MEM
    step(mk(32'hBFC00028, 1, 5'd11, 32'h0BADBEEF,
            0, 0, 0, 0), RUN, 5'd9, 5'd0);
    ex("rel_wen", S_WEN, 32'hF);
    ex("rel_pc", S_PC, 32'hBFC00020);
    ex("rel_rd1", S_RD1, 32'hCAFEF00D);
    // H in WB, MEM stalled -> bubble next
    step(mk(32'hBFC00030, 1, 5'd12, 32'h55555555,
            0, 0, 0, 0), BUBL, 5'd9, 5'd11);
    ex("h_pc", S_PC, 32'hBFC00028);
    ex("h_wen", S_WEN, 32'hF);
    ex("e_stored", S_RD1, 32'hCAFEF00D);
    ex("h_byp_rd2", S_RD2, 32'h0BADBEEF);
    // I: HI/LO plus r12, for the reset test
    step(mk(32'hBFC0002C, 1, 5'd12, 32'h00000012,
            1, 1, 32'd3, 32'd4), RUN, 5'd9, 5'd11);
    ex("bub2_pc", S_PC, 32'd0);
    ex("bub2_wen", S_WEN, 32'd0);
    ex("h_stored", S_RD2, 32'h0BADBEEF);
    step('0, RUN, 5'd12, 5'd9);
    ex("i_pc", S_PC, 32'hBFC0002C);
    ex("i_hi", S_HI, 32'd3);
    ex("i_rd1", S_RD1, 32'h00000012);
    // reset mid-cycle: everything drops at once
    step('0, RUN, 5'd12, 5'd9);
    rst = 1'b0;
    ex("mid_pc", S_PC, 32'd0);
    ex("mid_wen", S_WEN, 32'd0);
    ex("mid_hi", S_HI, 32'd0);
    ex("mid_lo", S_LO, 32'd0);
    ex("mid_rd1", S_RD1, 32'd0);
    ex("mid_rd2", S_RD2, 32'd0);
    ex("mid_frf", S_FRF, 32'd0);
    step('0, RUN, 5'd5, 5'd8);
    rst = 1'b1;
    ex("post_rd1", S_RD1, 32'd0);
    ex("post_rd2", S_RD2, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain actual=%0d required=0",
               q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
